// File: rtl/mem_wb_pkg.sv
// rtl/mem_wb_pkg.sv - shared opcodes, flag indices and op classification for mem_wb_stage
//
// Purpose : opcode localparams, flag bit positions, clear-FSM state type and
//           the is_wb_op / is_flag_op classifiers used by mem_wb_stage.
// Ports   : none (package).
// Options : DMEM_CLEAR_EN (the clear-FSM state type is always declared).
package mem_wb_pkg;

  localparam logic [4:0] OP_ADD   = 5'b00000;
  localparam logic [4:0] OP_STORE = 5'b10100;
  localparam logic [4:0] OP_LOAD  = 5'b10101;
  localparam logic [4:0] OP_JUMP  = 5'b11100;

  // Positions of the bits inside the {P,V,Z,C} flag vector
  localparam int FLAG_P = 3;
  localparam int FLAG_V = 2;
  localparam int FLAG_Z = 1;
  localparam int FLAG_C = 0;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } clr_state_t;

  // ALU ops: these write ans_ex back to the register file and update flags
  function automatic logic is_flag_op(input logic [4:0] op);
    logic r;
    r = 1'b0;
    case (op)
      5'b00000, 5'b00001, 5'b00010,
      5'b00100, 5'b00101, 5'b00110, 5'b00111,
      5'b01000, 5'b01001, 5'b01010,
      5'b01100, 5'b01101, 5'b01110, 5'b01111,
      5'b10110,
      5'b11001, 5'b11010, 5'b11011: r = 1'b1;
      default:                      r = 1'b0;
    endcase
    return r;
  endfunction

  // Anything that produces a register-file write: ALU ops plus LOAD
  function automatic logic is_wb_op(input logic [4:0] op);
    return is_flag_op(op) || (op == OP_LOAD);
  endfunction

endpackage

// File: rtl/dmem_sp.sv
// rtl/dmem_sp.sv - single-port synchronous-write, synchronous-read data memory
//
// Purpose : 2**AW x 8 RAM. Write and read both take effect on the rising edge.
//           The read register only updates on i_re, so o_rdata holds the last
//           loaded word between loads.
// Ports   : clk      - clock
//           i_we     - write enable
//           i_re     - read enable
//           i_addr   - word address
//           i_wdata  - write data
//           o_rdata  - registered read data
module dmem_sp #(
  parameter int AW = 8
) (
  input  logic          clk,
  input  logic          i_we,
  input  logic          i_re,
  input  logic [AW-1:0] i_addr,
  input  logic [7:0]    i_wdata,
  output logic [7:0]    o_rdata
);

  logic [7:0] r_mem [0:(1<<AW)-1];
  logic [7:0] r_rdata;

  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_addr] <= i_wdata;
    end
    if (i_re) begin
      r_rdata <= r_mem[i_addr];
    end
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/mem_wb_stage.sv
// rtl/mem_wb_stage.sv - memory access and register write-back stage of the 8-bit core
//
// Purpose : performs data-memory STORE/LOAD, latches the architectural flag
//           register and drives a registered register-file write port.
//           Optional macro DMEM_CLEAR_EN adds a post-reset memory clear FSM.
// Ports   : clk, reset      - clock, synchronous active-high reset
//           valid_ex        - execute result valid
//           Op_ex, rd_ex    - opcode and destination register aligned with ans_ex
//           ans_ex          - ALU result / memory address
//           DM_data         - store data
//           flag_ex         - {P,V,Z,C} from execute
//           wb_en/addr/data - register-file write port
//           flags           - architectural flags
//           busy            - stage not accepting ops
module mem_wb_stage
  import mem_wb_pkg::*;
#(
  parameter int AW = 8,
  parameter int RW = 3
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          valid_ex,
  input  logic [4:0]    Op_ex,
  input  logic [RW-1:0] rd_ex,
  input  logic [7:0]    ans_ex,
  input  logic [7:0]    DM_data,
  input  logic [3:0]    flag_ex,
  output logic          wb_en,
  output logic [RW-1:0] wb_addr,
  output logic [7:0]    wb_data,
  output logic [3:0]    flags,
  output logic          busy
);

  logic          w_accept;
  logic          w_is_store;
  logic          w_is_load;
  logic          w_clearing;
  logic [AW-1:0] w_clr_addr;
  logic          w_mem_we;
  logic          w_mem_re;
  logic [AW-1:0] w_mem_addr;
  logic [7:0]    w_mem_wdata;
  logic [7:0]    w_mem_rdata;

  logic          r_wb_en;
  logic [RW-1:0] r_wb_addr;
  logic [7:0]    r_alu_data;
  logic          r_sel_load;
  logic [3:0]    r_flags;

`ifdef DMEM_CLEAR_EN
  clr_state_t    r_state;
  logic [AW-1:0] r_cnt;
  logic          r_busy;

  // Walk every address once after reset, writing zero; reset restarts the walk
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_CLEAR;
      r_cnt   <= '0;
      r_busy  <= 1'b1;
    end else begin
      case (r_state)
        ST_CLEAR: begin
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == {AW{1'b1}}) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign w_clearing = (r_state == ST_CLEAR) && !reset;
  assign w_clr_addr = r_cnt;
  assign busy       = r_busy;
`else
  assign w_clearing = 1'b0;
  assign w_clr_addr = '0;
  assign busy       = 1'b0;
`endif

  // Reset wins over any op, so a STORE during reset never reaches memory
  assign w_accept   = valid_ex && !busy && !reset;
  assign w_is_store = (Op_ex == OP_STORE);
  assign w_is_load  = (Op_ex == OP_LOAD);

  assign w_mem_we    = w_clearing || (w_accept && w_is_store);
  assign w_mem_re    = w_accept && w_is_load;
  assign w_mem_addr  = w_clearing ? w_clr_addr : ans_ex[AW-1:0];
  assign w_mem_wdata = w_clearing ? 8'h00 : DM_data;

  dmem_sp #(
    .AW (AW)
  ) u_dmem (
    .clk     (clk),
    .i_we    (w_mem_we),
    .i_re    (w_mem_re),
    .i_addr  (w_mem_addr),
    .i_wdata (w_mem_wdata),
    .o_rdata (w_mem_rdata)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wb_en    <= 1'b0;
      r_wb_addr  <= '0;
      r_alu_data <= 8'h00;
      r_sel_load <= 1'b0;
      r_flags    <= 4'b0000;
    end else begin
      r_wb_en <= w_accept && is_wb_op(Op_ex);
      if (w_accept && is_wb_op(Op_ex)) begin
        r_wb_addr  <= rd_ex;
        r_sel_load <= w_is_load;
        if (!w_is_load) begin
          r_alu_data <= ans_ex;
        end
      end
      if (w_accept && is_flag_op(Op_ex)) begin
        r_flags <= flag_ex;
      end
    end
  end

  // Load data comes straight from the RAM read register, which only updates
  // on loads, so wb_data still holds its last value while wb_en is low.
  assign wb_en   = r_wb_en;
  assign wb_addr = r_wb_addr;
  assign wb_data = r_sel_load ? w_mem_rdata : r_alu_data;
  assign flags   = r_flags;

endmodule

// File: tb/tb_mem_wb_stage.sv
// tb/tb_mem_wb_stage.sv - directed self-checking bench for mem_wb_stage
module tb_mem_wb_stage;
  import mem_wb_pkg::*;

  localparam int AW = 8;
  localparam int RW = 3;

  logic          clk = 1'b0;
  logic          reset;
  logic          valid_ex;
  logic [4:0]    Op_ex;
  logic [RW-1:0] rd_ex;
  logic [7:0]    ans_ex;
  logic [7:0]    DM_data;
  logic [3:0]    flag_ex;
  logic          wb_en;
  logic [RW-1:0] wb_addr;
  logic [7:0]    wb_data;
  logic [3:0]    flags;
  logic          busy;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  mem_wb_stage #(.AW(AW), .RW(RW)) dut (
    .clk      (clk),
    .reset    (reset),
    .valid_ex (valid_ex),
    .Op_ex    (Op_ex),
    .rd_ex    (rd_ex),
    .ans_ex   (ans_ex),
    .DM_data  (DM_data),
    .flag_ex  (flag_ex),
    .wb_en    (wb_en),
    .wb_addr  (wb_addr),
    .wb_data  (wb_data),
    .flags    (flags),
    .busy     (busy)
  );

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [4:0] op, input logic [RW-1:0] rd,
                       input logic [7:0] a, input logic [7:0] d, input logic [3:0] f);
    valid_ex = v;
    Op_ex    = op;
    rd_ex    = rd;
    ans_ex   = a;
    DM_data  = d;
    flag_ex  = f;
    tick();
  endtask

  task automatic wait_ready(output int cycles);
    cycles = 0;
    while (busy && cycles < 2000) begin
      tick();
      cycles++;
    end
    if (busy) begin
      n_checks++;
      n_fail++;
      $display("FAIL busy_timeout: busy still 1 after %0d cycles", cycles);
    end
  endtask

  task automatic check_reset_state(input string tag);
    check_eq({tag, "_wb_en"},   32'(wb_en),   32'd0);
    check_eq({tag, "_wb_addr"}, 32'(wb_addr), 32'd0);
    check_eq({tag, "_wb_data"}, 32'(wb_data), 32'd0);
    check_eq({tag, "_flags"},   32'(flags),   32'd0);
`ifdef DMEM_CLEAR_EN
    check_eq({tag, "_busy"},    32'(busy),    32'd1);
`else
    check_eq({tag, "_busy"},    32'(busy),    32'd0);
`endif
  endtask

  int cyc;

  initial begin
    reset = 1'b1;
    valid_ex = 1'b0; Op_ex = 5'd0; rd_ex = '0; ans_ex = 8'h00; DM_data = 8'h00; flag_ex = 4'h0;
    tick();
    tick();
    check_reset_state("rst");
    reset = 1'b0;

`ifdef DMEM_CLEAR_EN
    wait_ready(cyc);
    check_eq("clear_cycles", 32'(cyc), 32'(1 << AW));
    // Restart the clear part-way through
    reset = 1'b1; tick(); reset = 1'b0;
    for (int i = 0; i < 8; i++) tick();
    reset = 1'b1; tick(); reset = 1'b0;
    wait_ready(cyc);
    check_eq("clear_restart_cycles", 32'(cyc), 32'(1 << AW));
    drive(1'b1, OP_LOAD, 3'd1, 8'h3C, 8'h00, 4'h0);
    check_eq("cleared_word", 32'(wb_data), 32'h00);
`endif

    // STORE then LOAD on the next cycle
    drive(1'b1, OP_STORE, 3'd0, 8'h3C, 8'hA5, 4'hF);
    check_eq("store_wb_en", 32'(wb_en), 32'd0);
    drive(1'b1, OP_LOAD, 3'd5, 8'h3C, 8'h00, 4'hF);
    check_eq("load_wb_en",   32'(wb_en),   32'd1);
    check_eq("load_wb_addr", 32'(wb_addr), 32'd5);
    check_eq("load_wb_data", 32'(wb_data), 32'hA5);
    check_eq("load_flags",   32'(flags),   32'h0);

    // ADD then JUMP
    drive(1'b1, OP_ADD, 3'd2, 8'h00, 8'h00, 4'b0011);
    check_eq("add_wb_en",   32'(wb_en),   32'd1);
    check_eq("add_wb_addr", 32'(wb_addr), 32'd2);
    check_eq("add_wb_data", 32'(wb_data), 32'h00);
    check_eq("add_flags",   32'(flags),   32'h3);
    drive(1'b1, OP_JUMP, 3'd6, 8'h44, 8'h00, 4'hF);
    check_eq("jump_wb_en",   32'(wb_en),   32'd0);
    check_eq("jump_flags",   32'(flags),   32'h3);
    check_eq("jump_wb_addr", 32'(wb_addr), 32'd2);

    // Invalid STORE is ignored
    drive(1'b1, OP_STORE, 3'd0, 8'h10, 8'h11, 4'h0);
    drive(1'b0, OP_STORE, 3'd0, 8'h10, 8'hFF, 4'h0);
    check_eq("idle_wb_en", 32'(wb_en), 32'd0);
    drive(1'b1, OP_LOAD, 3'd1, 8'h10, 8'h00, 4'h0);
    check_eq("load_after_idle",  32'(wb_data), 32'h11);
    check_eq("load_after_idle_a", 32'(wb_addr), 32'd1);
    check_eq("load_after_idle_f", 32'(flags),  32'h3);

    // Non-wb op holds wb_data from a load; undefined op keeps flags
    drive(1'b1, 5'b10000, 3'd4, 8'h77, 8'h00, 4'hF);
    check_eq("hold_wb_en",   32'(wb_en),   32'd0);
    check_eq("hold_wb_data", 32'(wb_data), 32'h11);
    drive(1'b1, 5'b00011, 3'd4, 8'h99, 8'h00, 4'hF);
    check_eq("undef_wb_en", 32'(wb_en), 32'd0);
    check_eq("undef_flags", 32'(flags), 32'h3);

    // Back-to-back ALU ops at the top of the opcode map
    drive(1'b1, 5'b11011, 3'd7, 8'hC3, 8'h00, 4'b1000);
    check_eq("op1b_wb_data", 32'(wb_data), 32'hC3);
    check_eq("op1b_flags",   32'(flags),   32'h8);
    drive(1'b1, 5'b10110, 3'd4, 8'h5A, 8'h00, 4'b0100);
    check_eq("op16_wb_en",   32'(wb_en),   32'd1);
    check_eq("op16_wb_addr", 32'(wb_addr), 32'd4);
    check_eq("op16_wb_data", 32'(wb_data), 32'h5A);
    check_eq("op16_flags",   32'(flags),   32'h4);
    drive(1'b0, OP_ADD, 3'd0, 8'h00, 8'h00, 4'h0);
    check_eq("pulse_wb_en", 32'(wb_en), 32'd0);

    // STORE during reset is dropped
    drive(1'b1, OP_STORE, 3'd0, 8'h7E, 8'h6B, 4'h0);
    reset = 1'b1;
    drive(1'b1, OP_STORE, 3'd0, 8'h7E, 8'hEE, 4'h0);
    reset = 1'b0;
    check_reset_state("rst2");
    wait_ready(cyc);
    drive(1'b1, OP_LOAD, 3'd3, 8'h7E, 8'h00, 4'h0);
    check_eq("rst_store_wb_en", 32'(wb_en), 32'd1);
`ifdef DMEM_CLEAR_EN
    check_eq("rst_store_data", 32'(wb_data), 32'h00);
`else
    check_eq("rst_store_data", 32'(wb_data), 32'h6B);
`endif
    check_eq("rst_store_flags", 32'(flags), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
